// File: rtl/xgmii_pkg.sv
// Shared XGMII word constants and the TX arbiter state encoding.
package xgmii_pkg;

  localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
  localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
  localparam logic [63:0] XGMII_ERR_D  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  XGMII_ERR_C  = 8'hFF;

  localparam logic [7:0]  XGMII_START  = 8'hFB;
  localparam logic [7:0]  XGMII_TERM   = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_IFG   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after the
// last winner, wrapping. Kept standalone so the RX dispatch can reuse it.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;

  // Scan from farthest to nearest offset so the nearest set request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IW'((int'(last) + off) % NREQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// Whole-frame round-robin arbiter onto one XGMII TX path, with a fixed
// idle gap after every frame, link gating and an oversize-frame watchdog.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | idle words out; arbitrate when link is up and anyone requests
// ST_GRANT | forward granted source one cycle late; end on eof or abort
// ST_IFG   | idle words out; count down the inter-frame gap
module xgmii_tx_arbiter
  import xgmii_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int IFG_WORDS = 2,
  parameter int MAX_WORDS = 1200
) (
  input  logic                xgmii_clk,
  input  logic                sys_rst,
  input  logic                link_up,
  input  logic [NREQ-1:0]     req,
  output logic [NREQ-1:0]     gnt,
  input  logic [NREQ*64-1:0]  src_txd,
  input  logic [NREQ*8-1:0]   src_txc,
  input  logic [NREQ-1:0]     src_eof,
  output logic [63:0]         xgmii_txd,
  output logic [7:0]          xgmii_txc,
  output logic                busy,
  output logic                trunc_pulse
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [15:0] WCNT_MAX = 16'(MAX_WORDS - 1);
  localparam logic [15:0] IFG_LOAD = 16'(IFG_WORDS - 1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   cur_q, cur_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [15:0]     ifg_q, ifg_d;
  logic [63:0]     txd_q, txd_d;
  logic [7:0]      txc_q, txc_d;
  logic            trunc_q, trunc_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [63:0]     sel_txd;
  logic [7:0]      sel_txc;
  logic            sel_eof;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req   (req),
    .last  (cur_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // cur_q is both the active grant and the round-robin last winner.
  assign sel_txd = src_txd[{cur_q, 6'b0} +: 64];
  assign sel_txc = src_txc[{cur_q, 3'b0} +: 8];
  assign sel_eof = src_eof[cur_q];

  // Next-state and next-output decode; idle word is the default output.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cur_d   = cur_q;
    wcnt_d  = wcnt_q;
    ifg_d   = ifg_q;
    txd_d   = XGMII_IDLE_D;
    txc_d   = XGMII_IDLE_C;
    trunc_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (link_up && pick_valid) begin
          gnt_d   = NREQ'(1) << pick_idx;
          cur_d   = pick_idx;
          wcnt_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // eof is checked first so a terminate always goes out intact.
        if (sel_eof) begin
          txd_d   = sel_txd;
          txc_d   = sel_txc;
          gnt_d   = '0;
          ifg_d   = IFG_LOAD;
          state_d = ST_IFG;
        end else if (!link_up || (wcnt_q >= WCNT_MAX)) begin
          txd_d   = XGMII_ERR_D;
          txc_d   = XGMII_ERR_C;
          trunc_d = 1'b1;
          gnt_d   = '0;
          ifg_d   = IFG_LOAD;
          state_d = ST_IFG;
        end else begin
          txd_d = sel_txd;
          txc_d = sel_txc;
          if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_IFG: begin
        if (ifg_q == '0) state_d = ST_IDLE;
        else             ifg_d   = ifg_q - 16'd1;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops straight to the idle word.
  always_ff @(posedge xgmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      cur_q   <= IW'(NREQ - 1);
      wcnt_q  <= '0;
      ifg_q   <= '0;
      txd_q   <= XGMII_IDLE_D;
      txc_q   <= XGMII_IDLE_C;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      wcnt_q  <= wcnt_d;
      ifg_q   <= ifg_d;
      txd_q   <= txd_d;
      txc_q   <= txc_d;
      trunc_q <= trunc_d;
    end
  end

  assign gnt         = gnt_q;
  assign xgmii_txd   = txd_q;
  assign xgmii_txc   = txc_q;
  assign trunc_pulse = trunc_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xgmii_tx_arbiter.sv
// Directed bench for xgmii_tx_arbiter (NREQ=2, IFG_WORDS=2, MAX_WORDS=1200).
`timescale 1ns/1ps
module tb_xgmii_tx_arbiter;
  import xgmii_pkg::*;

  localparam int NREQ = 2;
  localparam logic [71:0] IDLE_W = {XGMII_IDLE_C, XGMII_IDLE_D};
  localparam logic [71:0] ERR_W  = {XGMII_ERR_C, XGMII_ERR_D};

  logic                xgmii_clk;
  logic                sys_rst;
  logic                link_up;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     gnt;
  logic [NREQ*64-1:0]  src_txd;
  logic [NREQ*8-1:0]   src_txc;
  logic [NREQ-1:0]     src_eof;
  logic [63:0]         xgmii_txd;
  logic [7:0]          xgmii_txc;
  logic                busy;
  logic                trunc_pulse;

  int n_checks = 0;
  int n_errors = 0;

  int          widx [NREQ];
  int          flen [NREQ];
  bit          chk_fwd;
  bit          prev_fwd;
  logic [71:0] prev_word;

  xgmii_tx_arbiter #(.NREQ(NREQ), .IFG_WORDS(2), .MAX_WORDS(1200)) dut (
    .xgmii_clk   (xgmii_clk),
    .sys_rst     (sys_rst),
    .link_up     (link_up),
    .req         (req),
    .gnt         (gnt),
    .src_txd     (src_txd),
    .src_txc     (src_txc),
    .src_eof     (src_eof),
    .xgmii_txd   (xgmii_txd),
    .xgmii_txc   (xgmii_txc),
    .busy        (busy),
    .trunc_pulse (trunc_pulse)
  );

  initial xgmii_clk = 1'b0;
  always #3 xgmii_clk = ~xgmii_clk;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Source word i of a len-word frame from requester n: start, payload, terminate.
  function automatic logic [71:0] src_word(input int n, input int i, input int len);
    logic [63:0] d;
    logic [7:0]  c;
    if (i == 0) begin
      d = {{7{8'h55}}, XGMII_START};
      c = 8'h01;
    end else if (i == len - 1) begin
      d = {{7{8'h07}}, XGMII_TERM};
      c = 8'hFF;
    end else begin
      d = {4'hD, 4'(n), 24'h0, 32'(i)};
      c = 8'h00;
    end
    return {c, d};
  endfunction

  // Each source presents its next word while granted, restarting when not.
  task automatic drive_srcs();
    logic [71:0] w;
    prev_fwd = 1'b0;
    for (int n = 0; n < NREQ; n++) begin
      if (gnt[n]) begin
        w = src_word(n, widx[n], flen[n]);
        src_txd[n*64 +: 64] = w[63:0];
        src_txc[n*8 +: 8]   = w[71:64];
        src_eof[n]          = (widx[n] == flen[n] - 1);
        prev_fwd  = 1'b1;
        prev_word = w;
        widx[n]++;
      end else begin
        widx[n] = 0;
        src_txd[n*64 +: 64] = 64'hBADC0DE0BADC0DE0;
        src_txc[n*8 +: 8]   = 8'h00;
        src_eof[n]          = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge xgmii_clk);
    #1;
    check_eq("gnt_onehot0", 72'($onehot0(gnt)), 72'd1);
    if (chk_fwd)
      check_eq("fwd_word", {xgmii_txc, xgmii_txd}, prev_fwd ? prev_word : IDLE_W);
    drive_srcs();
  endtask

  task automatic wait_gnt(input string tag, input int n, input int budget, output int waited);
    waited = 0;
    while (!gnt[n] && waited < budget) begin
      cyc();
      waited++;
    end
    check_eq(tag, 72'(gnt[n]), 72'd1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    repeat (2) @(posedge xgmii_clk);
    #1;
    sys_rst = 1'b0;
    drive_srcs();
  endtask

  initial begin
    int          d, k, fwd, term_seen, idle_run, gcount;
    logic [NREQ-1:0] prev_gnt, gor;
    logic [NREQ-1:0] gseq [8];
    bit          idle_bad;

    sys_rst = 1'b1;
    link_up = 1'b1;
    req     = '0;
    src_txd = '0;
    src_txc = '0;
    src_eof = '0;
    chk_fwd = 1'b0;
    prev_fwd = 1'b0;
    prev_word = '0;
    for (int n = 0; n < NREQ; n++) begin
      widx[n] = 0;
      flen[n] = 8;
    end

    // Reset state, link up, nobody requesting.
    do_reset();
    repeat (3) cyc();
    check_eq("rst_txd", 72'(xgmii_txd), 72'(XGMII_IDLE_D));
    check_eq("rst_txc", 72'(xgmii_txc), 72'(XGMII_IDLE_C));
    check_eq("rst_gnt", 72'(gnt), 72'd0);
    check_eq("rst_busy", 72'(busy), 72'd0);
    check_eq("rst_trunc", 72'(trunc_pulse), 72'd0);

    // Both requesting 8-word frames: alternating grants, 3 idles between frames.
    chk_fwd   = 1'b1;
    req       = 2'b11;
    term_seen = 0;
    idle_run  = -1;
    gcount    = 0;
    for (int c = 0; c < 150 && term_seen < 4; c++) begin
      prev_gnt = gnt;
      cyc();
      if (gnt != '0 && prev_gnt == '0 && gcount < 8) begin
        gseq[gcount] = gnt;
        gcount++;
      end
      if (xgmii_txc == 8'hFF && xgmii_txd[7:0] == XGMII_TERM) begin
        term_seen++;
        idle_run = 0;
      end else if (xgmii_txc == 8'h01 && xgmii_txd[7:0] == XGMII_START) begin
        if (idle_run >= 0) check_eq("rr_ifg_gap", 72'(idle_run), 72'd3);
        idle_run = -1;
      end else if (idle_run >= 0 && {xgmii_txc, xgmii_txd} == IDLE_W) begin
        idle_run++;
      end
    end
    chk_fwd = 1'b0;
    check_eq("rr_frames", 72'(term_seen), 72'd4);
    check_eq("rr_gcount", 72'(gcount), 72'd4);
    for (int i = 0; i < 4 && i < gcount; i++)
      check_eq($sformatf("rr_gnt%0d", i), 72'(gseq[i]), (i % 2 == 0) ? 72'h1 : 72'h2);

    // Oversize frame on requester 0: 1199 words, error word, then grant to 1.
    req = '0;
    do_reset();
    flen[0] = 1500;
    flen[1] = 8;
    req = 2'b11;
    wait_gnt("wd_gnt0", 0, 10, d);
    k = 0;
    fwd = 0;
    while (k < 1300) begin
      cyc();
      k++;
      if (trunc_pulse) break;
      if (xgmii_txc != 8'hFF) fwd++;
    end
    check_eq("wd_cycles", 72'(k), 72'd1200);
    check_eq("wd_fwd_words", 72'(fwd), 72'd1199);
    check_eq("wd_err_word", {xgmii_txc, xgmii_txd}, ERR_W);
    check_eq("wd_gnt_drop", 72'(gnt), 72'd0);
    cyc();
    check_eq("wd_trunc_1cyc", 72'(trunc_pulse), 72'd0);
    check_eq("wd_idle_after", {xgmii_txc, xgmii_txd}, IDLE_W);
    wait_gnt("wd_gnt1", 1, 10, d);
    check_eq("wd_gnt1_delay", 72'(d), 72'd2);
    check_eq("wd_gnt1_only", 72'(gnt), 72'h2);

    // Link drops while word 5 is presented: error word next, no grant until link returns.
    req = '0;
    do_reset();
    flen[0] = 8;
    req = 2'b01;
    wait_gnt("ld_gnt0", 0, 10, d);
    repeat (5) cyc();
    check_eq("ld_word4", {xgmii_txc, xgmii_txd}, src_word(0, 4, 8));
    link_up = 1'b0;
    cyc();
    check_eq("ld_err_word", {xgmii_txc, xgmii_txd}, ERR_W);
    check_eq("ld_trunc", 72'(trunc_pulse), 72'd1);
    check_eq("ld_gnt_drop", 72'(gnt), 72'd0);
    gor = '0;
    idle_bad = 1'b0;
    repeat (20) begin
      cyc();
      gor |= gnt;
      if ({xgmii_txc, xgmii_txd} != IDLE_W) idle_bad = 1'b1;
    end
    check_eq("ld_no_gnt", 72'(gor), 72'd0);
    check_eq("ld_idle_out", 72'(idle_bad), 72'd0);
    check_eq("ld_not_busy", 72'(busy), 72'd0);
    link_up = 1'b1;
    wait_gnt("ld_regnt", 0, 5, d);
    check_eq("ld_regnt_delay", 72'(d), 72'd1);

    // eof and link loss on the same cycle: terminate goes out, no truncation.
    req = '0;
    do_reset();
    req = 2'b01;
    wait_gnt("eo_gnt0", 0, 10, d);
    repeat (7) cyc();
    link_up = 1'b0;
    cyc();
    check_eq("eo_term_word", {xgmii_txc, xgmii_txd}, src_word(0, 7, 8));
    check_eq("eo_trunc", 72'(trunc_pulse), 72'd0);
    check_eq("eo_gnt_drop", 72'(gnt), 72'd0);
    check_eq("eo_busy_ifg", 72'(busy), 72'd1);
    cyc();
    check_eq("eo_trunc2", 72'(trunc_pulse), 72'd0);
    cyc();
    cyc();
    check_eq("eo_idle_state", 72'(busy), 72'd0);
    cyc();
    check_eq("eo_no_gnt", 72'(gnt), 72'd0);
    link_up = 1'b1;

    // Async reset mid-frame, then first grant goes to requester 0.
    req = '0;
    do_reset();
    req = 2'b11;
    wait_gnt("ar_gnt0", 0, 10, d);
    repeat (3) cyc();
    sys_rst = 1'b1;
    #1;
    check_eq("ar_gnt", 72'(gnt), 72'd0);
    check_eq("ar_out", {xgmii_txc, xgmii_txd}, IDLE_W);
    check_eq("ar_busy", 72'(busy), 72'd0);
    check_eq("ar_trunc", 72'(trunc_pulse), 72'd0);
    @(posedge xgmii_clk);
    #1;
    sys_rst = 1'b0;
    drive_srcs();
    wait_gnt("ar_regnt", 0, 5, d);
    check_eq("ar_first_gnt", 72'(gnt), 72'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
